// File: rtl/x_firewall_pkg.sv
// rtl/x_firewall_pkg.sv - shared types and helpers for the multi-channel X/Z firewall
// Contents: xfw_state_e (monitor FSM states), sat_inc (saturating counter step).
package x_firewall_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    MONITOR,
    TRIPPED
  } xfw_state_e;

  // One saturating increment step. Counters of any width up to 32 bits go
  // through this helper zero-extended, with their own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/x_firewall_chan.sv
// rtl/x_firewall_chan.sv - one monitored channel: unknown-value hit detect, sticky flag, saturating count
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   count_en       top-level FSM is in MONITOR or TRIPPED with the monitor enabled
//   clr            qualified clear from the top level
//   valid, data    the channel's qualifier and bus slice
//   hit            combinational: this channel carries an unknown this cycle
//   sticky, cnt    registered error flag and saturating error count
module x_firewall_chan
  import x_firewall_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_en,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             hit,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  // Reduction XOR turns any X/Z bit into X. An unknown qualifier is treated
  // as a hit on its own, whatever the data looks like.
  assign hit = ((valid === 1'b1) && ((^data) === 1'bx)) || ((^valid) === 1'bx);

  // A hit in the same cycle as clear wins: the channel restarts at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (count_en && hit) begin
      sticky <= 1'b1;
      cnt    <= clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt), CNT_MAX));
    end else if (clr) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end
  end

endmodule

// File: rtl/x_firewall_mc.sv
// rtl/x_firewall_mc.sv - clocked multi-channel X/Z monitor with arming delay, sticky flags, counters, first-failure capture
// Optional feature macro: XFW_FATAL_EN (defined: $fatal on entry to TRIPPED;
// undefined: one $error per channel per rising edge of err_sticky).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         1 = monitor active, otherwise IDLE with outputs held
//   clear          zeroes flags, counters and first-failure capture
//   ch_data        CHANNELS buses of WIDTH bits, channel c at [c*WIDTH +: WIDTH]
//   ch_valid       per-channel qualifier
//   err_sticky     per-channel sticky error flag
//   err_cnt        per-channel saturating error count, CNT_W bits each
//   first_ch       lowest failing channel index captured on the trip
//   first_vld      first_ch holds a captured index
//   tripped        FSM is in TRIPPED
//   irq            one-cycle pulse on MONITOR -> TRIPPED
// MSG_EN gates the simulation messages only; register behaviour ignores it.
module x_firewall_mc
  import x_firewall_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int ARM_DLY  = 4,
  parameter bit MSG_EN   = 1'b1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic                                            clear,
  input  logic [CHANNELS*WIDTH-1:0]                       ch_data,
  input  logic [CHANNELS-1:0]                             ch_valid,
  output logic [CHANNELS-1:0]                             err_sticky,
  output logic [CHANNELS*CNT_W-1:0]                       err_cnt,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch,
  output logic                                            first_vld,
  output logic                                            tripped,
  output logic                                            irq
);

  localparam int FCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = (ARM_DLY > 0) ? $clog2(ARM_DLY + 1) : 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("x_firewall_mc: WIDTH must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("x_firewall_mc: CHANNELS must be >= 1");
  end

  xfw_state_e     state, state_nxt;
  logic [AW-1:0]  arm_cnt, arm_nxt;
  logic [CHANNELS-1:0] hit;
  logic [FCW-1:0] first_nxt;
  logic           en, clr, count_en, any_hit, trip;

  // An unknown enable or clear is treated as inactive.
  assign en       = (enable === 1'b1);
  assign clr      = en && (clear === 1'b1);
  assign count_en = en && ((state == MONITOR) || (state == TRIPPED));
  assign any_hit  = |hit;
  assign trip     = en && (state == MONITOR) && any_hit;
  assign tripped  = (state == TRIPPED);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    x_firewall_chan #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .count_en(count_en),
      .clr     (clr),
      .valid   (ch_valid[c]),
      .data    (ch_data[c*WIDTH +: WIDTH]),
      .hit     (hit[c]),
      .sticky  (err_sticky[c]),
      .cnt     (err_cnt[c*CNT_W +: CNT_W])
    );
  end

  // Lowest index wins: scan downwards so the last assignment is the smallest.
  always_comb begin
    first_nxt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (hit[i]) first_nxt = FCW'(i);
    end
  end

  // ARMING lasts max(1, ARM_DLY) cycles: the counter is loaded with ARM_DLY
  // and the FSM leaves once it has counted down to one (or started at zero).
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARMING;
          arm_nxt   = AW'(ARM_DLY);
        end
        ARMING: begin
          if (arm_cnt <= AW'(1)) state_nxt = MONITOR;
          else                   arm_nxt   = arm_cnt - AW'(1);
        end
        MONITOR: begin
          if (any_hit) state_nxt = TRIPPED;
        end
        TRIPPED: begin
          if (clr) state_nxt = MONITOR;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= en ? ARMING : IDLE;
      arm_cnt <= AW'(ARM_DLY);
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_nxt;
    end
  end

  // Capture on the trip edge takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_ch  <= '0;
      first_vld <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= trip;
      if (trip) begin
        first_ch  <= first_nxt;
        first_vld <= 1'b1;
      end else if (clr) begin
        first_ch  <= '0;
        first_vld <= 1'b0;
      end
    end
  end

`ifdef XFW_FATAL_EN
  always_ff @(posedge clk) begin
    if (MSG_EN && !reset && trip)
      $fatal(1, "x_firewall_mc: unknown value on channel %0d at time %0t", first_nxt, $time);
  end
`else
  logic [CHANNELS-1:0] sticky_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_seen <= '0;
    end else begin
      sticky_seen <= err_sticky;
      for (int i = 0; i < CHANNELS; i++) begin
        if (MSG_EN && err_sticky[i] && !sticky_seen[i])
          $error("x_firewall_mc: unknown value on channel %0d at time %0t", i, $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_x_firewall_mc.sv
// tb/tb_x_firewall_mc.sv - self-checking bench for x_firewall_mc against a rule-level reference model
module tb_x_firewall_mc;

  localparam int W    = 8;
  localparam int C    = 4;
  localparam int CW   = 2;
  localparam int AD   = 4;
  localparam int CMAX = 3;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MON  = 2;
  localparam int M_TRIP = 3;

  logic           clk = 1'b0;
  logic           reset, enable, clear;
  logic [C*W-1:0] ch_data;
  logic [C-1:0]   ch_valid;
  logic [C-1:0]   err_sticky;
  logic [C*CW-1:0] err_cnt;
  logic [1:0]     first_ch;
  logic           first_vld, tripped, irq;

  always #5 clk = ~clk;

  x_firewall_mc #(
    .WIDTH(W), .CHANNELS(C), .CNT_W(CW), .ARM_DLY(AD), .MSG_EN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .first_ch(first_ch),
    .first_vld(first_vld), .tripped(tripped), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_arm, m_first;
  bit m_fvld, m_irq;
  bit m_sticky[C];
  int m_cnt[C];

  function automatic bit exp_hit(int c);
    logic [W-1:0] s;
    logic v;
    s = ch_data[c*W +: W];
    v = ch_valid[c];
    return ((v === 1'b1) && ((^s) === 1'bx)) || (v === 1'bx) || (v === 1'bz);
  endfunction

  function automatic logic [C-1:0] exp_sticky();
    logic [C-1:0] r;
    for (int c = 0; c < C; c++) r[c] = m_sticky[c];
    return r;
  endfunction

  function automatic logic [C*CW-1:0] exp_cnt();
    logic [C*CW-1:0] r;
    for (int c = 0; c < C; c++) r[c*CW +: CW] = CW'(m_cnt[c]);
    return r;
  endfunction

  task automatic model_update();
    bit hits[C];
    bit any_h, clr_m, counting;
    int low;
    if (reset === 1'b1) begin
      m_state = (enable === 1'b1) ? M_ARM : M_IDLE;
      m_arm = AD; m_first = 0; m_fvld = 0; m_irq = 0;
      for (int c = 0; c < C; c++) begin m_sticky[c] = 0; m_cnt[c] = 0; end
      return;
    end
    if (enable !== 1'b1) begin
      m_state = M_IDLE; m_irq = 0;
      return;
    end
    clr_m = (clear === 1'b1);
    any_h = 0; low = -1;
    for (int c = 0; c < C; c++) begin
      hits[c] = exp_hit(c);
      if (hits[c] && low < 0) low = c;
      any_h |= hits[c];
    end
    counting = (m_state == M_MON) || (m_state == M_TRIP);
    for (int c = 0; c < C; c++) begin
      if (counting && hits[c]) begin
        m_sticky[c] = 1;
        m_cnt[c] = clr_m ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
      end else if (clr_m) begin
        m_sticky[c] = 0; m_cnt[c] = 0;
      end
    end
    m_irq = 0;
    if (m_state == M_MON && any_h) begin
      m_first = low; m_fvld = 1; m_irq = 1;
    end else if (clr_m) begin
      m_first = 0; m_fvld = 0;
    end
    case (m_state)
      M_IDLE: begin m_state = M_ARM; m_arm = AD; end
      M_ARM:  if (m_arm <= 1) m_state = M_MON; else m_arm--;
      M_MON:  if (any_h) m_state = M_TRIP;
      default: if (clr_m) m_state = M_MON;
    endcase
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int c, logic [W-1:0] d, logic v);
    ch_data[c*W +: W] = d;
    ch_valid[c] = v;
  endtask

  function automatic logic [W-1:0] clean_word();
    logic [W-1:0] r;
    r = W'($urandom);
    if (^r == 1'b0) r[0] = ~r[0];
    return r;
  endfunction

  task automatic all_clean();
    for (int c = 0; c < C; c++) set_ch(c, clean_word(), 1'b1);
  endtask

  function automatic logic [W-1:0] with_unknown(int bitpos, bit use_z);
    logic [W-1:0] r;
    r = clean_word();
    r[bitpos] = use_z ? 1'bz : 1'bx;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    all_clean();
    step(); step();
    if (err_sticky !== 4'b0 || err_cnt !== 8'b0 || first_vld !== 1'b0 ||
        first_ch !== 2'b0 || tripped !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sticky=%b cnt=%h fv=%b fc=%0d trip=%b irq=%b, want all 0",
               err_sticky, err_cnt, first_vld, first_ch, tripped, irq);
    end
    checks++;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < C; c++) set_ch(c, 'x, 1'b1);
      step();
      if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || tripped !== 1'b0) begin
        errors++;
        $display("FAIL arming_ignores_x[%0d]: got sticky=%b cnt=%h trip=%b, want sticky=%b cnt=%h trip=0",
                 k, err_sticky, err_cnt, tripped, exp_sticky(), exp_cnt());
      end
      checks++;
    end
    all_clean();
    step();
  endtask

  task automatic test_single_hit();
    all_clean();
    set_ch(1, with_unknown(3, 1'b0), 1'b1);
    step();
    if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || first_ch !== 2'(m_first) ||
        first_vld !== m_fvld || irq !== m_irq || tripped !== (m_state == M_TRIP)) begin
      errors++;
      $display("FAIL single_hit: got sticky=%b cnt=%h fc=%0d fv=%b irq=%b trip=%b, want sticky=%b cnt=%h fc=%0d fv=%b irq=%b trip=%b",
               err_sticky, err_cnt, first_ch, first_vld, irq, tripped,
               exp_sticky(), exp_cnt(), m_first, m_fvld, m_irq, m_state == M_TRIP);
    end
    checks++;
    all_clean();
    step();
    if (irq !== m_irq || tripped !== (m_state == M_TRIP)) begin
      errors++;
      $display("FAIL irq_one_cycle: got irq=%b trip=%b, want irq=%b trip=%b",
               irq, tripped, m_irq, m_state == M_TRIP);
    end
    checks++;
  endtask

  task automatic test_multi_hit();
    all_clean(); clear = 1'b1; step(); clear = 1'b0;
    set_ch(2, 'z, 1'b1);
    set_ch(3, 'z, 1'b1);
    step();
    if (first_ch !== 2'(m_first) || first_vld !== m_fvld || err_sticky !== exp_sticky()) begin
      errors++;
      $display("FAIL simultaneous_hits: got fc=%0d fv=%b sticky=%b, want fc=%0d fv=%b sticky=%b",
               first_ch, first_vld, err_sticky, m_first, m_fvld, exp_sticky());
    end
    checks++;
    all_clean(); clear = 1'b1; step(); clear = 1'b0;
    set_ch(3, 'x, 1'b0);
    step();
    if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || tripped !== (m_state == M_TRIP)) begin
      errors++;
      $display("FAIL invalid_channel: got sticky=%b cnt=%h trip=%b, want sticky=%b cnt=%h trip=%b",
               err_sticky, err_cnt, tripped, exp_sticky(), exp_cnt(), m_state == M_TRIP);
    end
    checks++;
  endtask

  task automatic test_saturate();
    all_clean(); clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_ch(0, with_unknown(k % W, k[0]), 1'b1);
      step();
      if (err_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL saturate[%0d]: got cnt=%h want cnt=%h", k, err_cnt, exp_cnt());
      end
      checks++;
    end
    all_clean(); clear = 1'b1; step(); clear = 1'b0;
    if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || first_vld !== m_fvld ||
        tripped !== (m_state == M_TRIP)) begin
      errors++;
      $display("FAIL clear_no_hit: got sticky=%b cnt=%h fv=%b trip=%b, want sticky=%b cnt=%h fv=%b trip=%b",
               err_sticky, err_cnt, first_vld, tripped, exp_sticky(), exp_cnt(), m_fvld, m_state == M_TRIP);
    end
    checks++;
  endtask

  task automatic test_clear_hit();
    all_clean();
    set_ch(0, with_unknown(5, 1'b0), 1'b1);
    step();
    clear = 1'b1;
    set_ch(0, with_unknown(1, 1'b0), 1'b1);
    step();
    clear = 1'b0;
    if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || tripped !== (m_state == M_TRIP) ||
        first_vld !== m_fvld) begin
      errors++;
      $display("FAIL clear_with_hit: got sticky=%b cnt=%h trip=%b fv=%b, want sticky=%b cnt=%h trip=%b fv=%b",
               err_sticky, err_cnt, tripped, first_vld, exp_sticky(), exp_cnt(), m_state == M_TRIP, m_fvld);
    end
    checks++;
    all_clean();
    set_ch(1, with_unknown(0, 1'b1), 1'b1);
    step();
    if (irq !== m_irq || tripped !== (m_state == M_TRIP) || first_ch !== 2'(m_first)) begin
      errors++;
      $display("FAIL retrip: got irq=%b trip=%b fc=%0d, want irq=%b trip=%b fc=%0d",
               irq, tripped, first_ch, m_irq, m_state == M_TRIP, m_first);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    all_clean();
    step();
    reset = 1'b0;
    if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || tripped !== 1'b0 ||
        irq !== 1'b0 || first_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sticky=%b cnt=%h trip=%b irq=%b fv=%b, want sticky=%b cnt=%h trip=0 irq=0 fv=0",
               err_sticky, err_cnt, tripped, irq, first_vld, exp_sticky(), exp_cnt());
    end
    checks++;
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < C; c++) set_ch(c, 'x, 1'b1);
      step();
      if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || tripped !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignores_x[%0d]: got sticky=%b cnt=%h trip=%b irq=%b, want sticky=%b cnt=%h trip=0 irq=0",
                 k, err_sticky, err_cnt, tripped, irq, exp_sticky(), exp_cnt());
      end
      checks++;
    end
    enable = 1'b1;
    all_clean();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 15) != 0);
      clear  = enable && ($urandom_range(0, 15) == 0);
      for (int c = 0; c < C; c++) begin
        logic [W-1:0] d;
        logic v;
        d = clean_word();
        if ($urandom_range(0, 7) == 0) d = with_unknown($urandom_range(0, W - 1), $urandom_range(0, 1) == 1);
        case ($urandom_range(0, 15))
          0:       v = 1'bx;
          1, 2, 3: v = 1'b0;
          default: v = 1'b1;
        endcase
        set_ch(c, d, v);
      end
      step();
      if (err_sticky !== exp_sticky() || err_cnt !== exp_cnt() || first_ch !== 2'(m_first) ||
          first_vld !== m_fvld || irq !== m_irq || tripped !== (m_state == M_TRIP)) begin
        errors++;
        $display("FAIL random[%0d]: got sticky=%b cnt=%h fc=%0d fv=%b irq=%b trip=%b, want sticky=%b cnt=%h fc=%0d fv=%b irq=%b trip=%b",
                 k, err_sticky, err_cnt, first_ch, first_vld, irq, tripped,
                 exp_sticky(), exp_cnt(), m_first, m_fvld, m_irq, m_state == M_TRIP);
      end
      checks++;
    end
    reset = 1'b0; enable = 1'b1; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    ch_data = '0; ch_valid = '0;
    m_state = M_IDLE; m_arm = AD; m_first = 0; m_fvld = 0; m_irq = 0;
    for (int c = 0; c < C; c++) begin m_sticky[c] = 0; m_cnt[c] = 0; end
    #1;
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_saturate();
    test_clear_hit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
